// File: rtl/l2_stats_pkg.sv
// Shared types and constants for the L2 statistics collector and its divider.
package l2_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } stats_state_t;

    localparam int EV_HIT   = 0;
    localparam int EV_MISS  = 1;
    localparam int EV_READ  = 2;
    localparam int EV_WRITE = 3;

endpackage

// File: rtl/l2_stats_divider.sv
// Sequential restoring divider producing Q_W quotient bits, one per cycle,
// with the first bit resolved on the start edge. A zero divisor yields zero.
module l2_stats_divider #(
    parameter int DVD_W = 48,
    parameter int DVS_W = 33,
    parameter int Q_W   = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [Q_W-1:0]   dvdBits;
    logic [Q_W-1:0]   qAcc;
    logic [CNT_W-1:0] iter;
    logic             zeroDiv;

    logic [DVS_W-1:0] initRem;
    logic [DVS_W-1:0] curRem;
    logic [DVS_W-1:0] curDvs;
    logic             curBit;
    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;
    logic             fits;
    logic [DVS_W-1:0] nextRem;

    // The caller guarantees dividend < divisor << Q_W, so the bits above the
    // quotient window seed the partial remainder without further steps.
    always_comb begin
        initRem = DVS_W'(dividend >> Q_W);
        curRem  = start ? initRem : rem;
        curDvs  = start ? divisor : dvs;
        curBit  = start ? dividend[Q_W-1] : dvdBits[Q_W-1];
        trial   = {curRem, curBit};
        diff    = trial - {1'b0, curDvs};
        fits    = (trial >= {1'b0, curDvs});
        nextRem = fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            rem      <= '0;
            dvs      <= '0;
            dvdBits  <= '0;
            qAcc     <= '0;
            iter     <= '0;
            zeroDiv  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                iter    <= CNT_W'(1);
                rem     <= nextRem;
                qAcc    <= {{(Q_W-1){1'b0}}, fits};
                dvdBits <= {dividend[Q_W-2:0], 1'b0};
                dvs     <= divisor;
                zeroDiv <= (divisor == '0);
            end else if (busy) begin
                rem     <= nextRem;
                qAcc    <= {qAcc[Q_W-2:0], fits};
                dvdBits <= {dvdBits[Q_W-2:0], 1'b0};
                iter    <= iter + CNT_W'(1);
                if (iter == CNT_W'(Q_W - 1)) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= zeroDiv ? '0 : {qAcc[Q_W-2:0], fits};
                end
            end
        end
    end

endmodule

// File: rtl/l2_stats_collector.sv
// Saturating L2 event counter bank with snapshot shadow registers, a
// registered read-out port and a multi-cycle hit/(hit+miss) ratio.
module l2_stats_collector #(
    parameter int NUM_EVENTS  = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int RATIO_FRAC  = 16,
    parameter int HIT_IDX     = 0,
    parameter int MISS_IDX    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_EVENTS-1:0]         event_valid,
    input  logic                          clear,
    input  logic                          snap_req,
    output logic                          snap_busy,
    output logic                          snap_done,
    input  logic [$clog2(NUM_EVENTS)-1:0] rd_sel,
    output logic [COUNT_WIDTH-1:0]        rd_data,
    output logic [RATIO_FRAC:0]           ratio,
    output logic [NUM_EVENTS-1:0]         saturated,
    output logic [1:0]                    dbgState
);

    import l2_stats_pkg::*;

    localparam int DVD_W = COUNT_WIDTH + RATIO_FRAC;
    localparam int DVS_W = COUNT_WIDTH + 1;
    localparam int Q_W   = RATIO_FRAC + 1;

    // Handshake: snap_req is a one-cycle request honoured only in ST_IDLE;
    // snap_busy stays high until the edge that raises the snap_done pulse,
    // and ratio is valid from that pulse until the next one.

    logic [COUNT_WIDTH-1:0] liveCnt [NUM_EVENTS];
    logic [COUNT_WIDTH-1:0] shadow  [NUM_EVENTS];
    stats_state_t           state;

    logic             takeSnap;
    logic [DVD_W-1:0] divDividend;
    logic [DVS_W-1:0] divDivisor;
    logic             divBusy;
    logic             divDone;
    logic [Q_W-1:0]   divQuot;

    assign takeSnap    = (state == ST_IDLE) && snap_req;
    assign divDividend = {liveCnt[HIT_IDX], {RATIO_FRAC{1'b0}}};
    assign divDivisor  = {1'b0, liveCnt[HIT_IDX]} + {1'b0, liveCnt[MISS_IDX]};
    assign dbgState    = state;

    // Clear has priority over any event arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EVENTS; i++) liveCnt[i] <= '0;
            saturated <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_EVENTS; i++) liveCnt[i] <= '0;
            saturated <= '0;
        end else if (enable) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (event_valid[i]) begin
                    if (liveCnt[i] == {COUNT_WIDTH{1'b1}}) saturated[i] <= 1'b1;
                    else liveCnt[i] <= liveCnt[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= '0;
        end else if (takeSnap) begin
            for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= liveCnt[i];
        end
    end

    l2_stats_divider #(
        .DVD_W (DVD_W),
        .DVS_W (DVS_W),
        .Q_W   (Q_W)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (takeSnap),
        .dividend (divDividend),
        .divisor  (divDivisor),
        .busy     (divBusy),
        .done     (divDone),
        .quotient (divQuot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            snap_busy <= 1'b0;
            snap_done <= 1'b0;
            ratio     <= '0;
        end else begin
            snap_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (snap_req) begin
                        state     <= ST_DIV;
                        snap_busy <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (divDone && !divBusy) state <= ST_DONE;
                end
                ST_DONE: begin
                    ratio     <= divQuot;
                    snap_done <= 1'b1;
                    snap_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else if (32'(rd_sel) < NUM_EVENTS) rd_data <= shadow[rd_sel];
        else rd_data <= '0;
    end

endmodule
